cfg_reg_bank: RTL
=================

CFG_REG_BANK -- requirements
Module: cfg_reg_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 8, register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, address width; depth is 2**ADDR_W.
REQ-003 SHALL have parameter NUM_EXP, default 4, count of registers 0..NUM_EXP-1 driven continuously onto cfg_regs; legal range 1..2**ADDR_W.
REQ-004 SHALL have parameter RO_MASK, default all-zero, 2**ADDR_W bits; bit i=1 makes register i read-only.
REQ-005 SHALL have parameter RST_VAL, flat (2**ADDR_W)*DATA_W vector; default reg2=0x81, reg3=0x20, all others 0x00.
REQ-006 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, asynchronous, active-low.
REQ-009 wr_en  input  1  write request, this cycle.
REQ-010 rd_en  input  1  read request, this cycle.
REQ-011 addr  input  ADDR_W  register index, shared by read and write.
REQ-012 wr_data  input  DATA_W  write data.
REQ-013 wr_mask  input  DATA_W  per-bit write enable; 1 = bit updated.
REQ-014 rd_data  output  DATA_W  read data, held until the next read completes.
REQ-015 rd_vld  output  1  one-cycle pulse, rd_data valid.
REQ-016 wr_err  output  1  one-cycle pulse, write to a read-only register rejected.
REQ-017 cfg_regs  output  NUM_EXP*DATA_W  registers 0..NUM_EXP-1, register 0 in LSBs.
REQ-018 cfg_upd  output  1  one-cycle pulse, an exposed register changed value.

Function
REQ-019 Write: if wr_en=1 and RO_MASK[addr]=0, then mem[addr] <= (mem[addr] & ~wr_mask) | (wr_data & wr_mask) at the rising edge.
REQ-020 Read-only write: if wr_en=1 and RO_MASK[addr]=1, then mem is unchanged and wr_err=1 in the following cycle.
REQ-021 Read: rd_en=1 samples mem[addr] as it was before any same-edge write; rd_data and rd_vld appear RD_LAT cycles after the request edge.
REQ-022 Simultaneous rd_en and wr_en: both SHALL be performed; the read returns the pre-write value and rd_vld still pulses.
REQ-023 Back-to-back reads on consecutive cycles SHALL each produce one rd_vld pulse, in order, at full throughput for both RD_LAT values.
REQ-024 rd_vld SHALL be 0 in every cycle with no read completing; rd_data SHALL hold its last value.
REQ-025 cfg_upd SHALL pulse one cycle after an accepted write to an index < NUM_EXP whose masked result differs from the old value; no pulse for identical data or wr_mask=0.
REQ-026 cfg_regs SHALL reflect a write combinationally from register state in the cycle after the write edge.
REQ-027 A write with wr_mask=0 SHALL be accepted with no state change and no wr_err.

Reset
REQ-028 On rst low: every mem[i] <= RST_VAL slice i; rd_data=0, rd_vld=0, wr_err=0, cfg_upd=0; read pipeline flushed.
REQ-029 A read in flight when reset asserts SHALL be discarded with no rd_vld after release.
REQ-030 Reset deassertion is synchronised externally; the first request is accepted on the first edge with rst high.

Structure
REQ-031 Package cfg_reg_pkg SHALL hold the default RST_VAL constant, the legal RD_LAT values and the NUM_EXP default.
REQ-032 Sub-module cfg_reg_rd_pipe SHALL implement the 1- or 2-stage rd_data/rd_vld delay, reset to zero.
REQ-033 An elaboration-time check SHALL reject RD_LAT outside {1,2} and NUM_EXP outside its legal range.

Verification
REQ-034 Reset then read reg2, reg3, reg0 -> rd_data 0x81, 0x20, 0x00; one rd_vld per read after RD_LAT cycles.
REQ-035 Write reg1 with data 0xFF and mask 0x0F, then read reg1 -> 0x0F; cfg_upd pulses once; cfg_regs[15:8]=0x0F.
REQ-036 RO_MASK bit 5 set; write 0xAA to reg5 -> wr_err pulses; read reg5 returns its RST_VAL; no cfg_upd.
REQ-037 Same cycle: write 0x55 to reg0 and read reg0 -> read returns 0x00; the next read returns 0x55.
REQ-038 Four consecutive reads at RD_LAT=2 -> four consecutive rd_vld pulses starting 2 cycles after the first request, data in request order.
REQ-039 Assert rst one cycle after a read request at RD_LAT=2 -> no rd_vld, all registers return to RST_VAL, cfg_upd stays 0.

Source files
------------

// File: rtl/cfg_reg_pkg.sv
// Shared constants for the configuration register bank: default reset image,
// default exposure count and the legal read latencies.
package cfg_reg_pkg;

   localparam int unsigned CFG_DATA_W_DEF  = 8;
   localparam int unsigned CFG_ADDR_W_DEF  = 4;
   localparam int unsigned CFG_NUM_EXP_DEF = 4;

   // Register 2 = 0x81, register 3 = 0x20, everything else zero (reg 0 in LSBs).
   localparam logic [(2**CFG_ADDR_W_DEF)*CFG_DATA_W_DEF-1:0] CFG_RST_VAL_DEF =
      128'h0000_0000_0000_0000_0000_0000_2081_0000;

   typedef enum int unsigned {
      RD_LAT_1 = 1,
      RD_LAT_2 = 2
   } rd_lat_e;

   function automatic bit rd_lat_legal(input int unsigned lat);
      return (lat == int'(RD_LAT_1)) || (lat == int'(RD_LAT_2));
   endfunction

endpackage

// File: rtl/cfg_reg_rd_pipe.sv
// Read-return delay line: one or two register stages carrying data and valid.
// The output data stage only loads on valid so the last read result is held.
module cfg_reg_rd_pipe
   import cfg_reg_pkg::*;
#(
   parameter int unsigned DATA_W = CFG_DATA_W_DEF,
   parameter int unsigned LAT    = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              vld_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              vld_o,
   output logic [DATA_W-1:0] data_o
);

   logic              vld1_q;
   logic [DATA_W-1:0] data1_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         vld1_q  <= 1'b0;
         data1_q <= '0;
      end else begin
         vld1_q <= vld_i;
         if (vld_i) begin
            data1_q <= data_i;
         end
      end
   end

   if (LAT == int'(RD_LAT_2)) begin : g_two_stage
      logic              vld2_q;
      logic [DATA_W-1:0] data2_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            vld2_q  <= 1'b0;
            data2_q <= '0;
         end else begin
            vld2_q <= vld1_q;
            if (vld1_q) begin
               data2_q <= data1_q;
            end
         end
      end

      assign vld_o  = vld2_q;
      assign data_o = data2_q;
   end else begin : g_one_stage
      assign vld_o  = vld1_q;
      assign data_o = data1_q;
   end

endmodule

// File: rtl/cfg_reg_bank.sv
// Configuration register bank: masked writes, per-register read-only protection,
// pipelined reads and a continuously exposed low register window.
module cfg_reg_bank
   import cfg_reg_pkg::*;
#(
   parameter int unsigned                          DATA_W  = CFG_DATA_W_DEF,
   parameter int unsigned                          ADDR_W  = CFG_ADDR_W_DEF,
   parameter int unsigned                          NUM_EXP = CFG_NUM_EXP_DEF,
   parameter logic [(2**ADDR_W)-1:0]               RO_MASK = '0,
   parameter logic [(2**ADDR_W)*DATA_W-1:0]        RST_VAL = CFG_RST_VAL_DEF,
   parameter int unsigned                          RD_LAT  = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic                      rd_en,
   input  logic [ADDR_W-1:0]         addr,
   input  logic [DATA_W-1:0]         wr_data,
   input  logic [DATA_W-1:0]         wr_mask,
   output logic [DATA_W-1:0]         rd_data,
   output logic                      rd_vld,
   output logic                      wr_err,
   output logic [NUM_EXP*DATA_W-1:0] cfg_regs,
   output logic                      cfg_upd
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   if (!rd_lat_legal(RD_LAT)) begin : g_bad_rd_lat
      $error("cfg_reg_bank: RD_LAT must be 1 or 2");
   end
   if ((NUM_EXP < 1) || (NUM_EXP > DEPTH)) begin : g_bad_num_exp
      $error("cfg_reg_bank: NUM_EXP must be in 1..2**ADDR_W");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] old_val;
   logic [DATA_W-1:0] mem_d;
   logic              wr_ok;
   logic              wr_err_d;
   logic              wr_err_q;
   logic              cfg_upd_d;
   logic              cfg_upd_q;

   // old_val feeds both the write merge and the read pipe, so a same-edge
   // read always returns the pre-write contents.
   always_comb begin
      old_val   = mem_q[addr];
      mem_d     = (old_val & ~wr_mask) | (wr_data & wr_mask);
      wr_ok     = wr_en & ~RO_MASK[addr];
      wr_err_d  = wr_en & RO_MASK[addr];
      cfg_upd_d = wr_ok && (32'(addr) < NUM_EXP) && (mem_d != old_val);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= RST_VAL[i*DATA_W +: DATA_W];
         end
         wr_err_q  <= 1'b0;
         cfg_upd_q <= 1'b0;
      end else begin
         if (wr_ok) begin
            mem_q[addr] <= mem_d;
         end
         wr_err_q  <= wr_err_d;
         cfg_upd_q <= cfg_upd_d;
      end
   end

   always_comb begin
      cfg_regs = '0;
      for (int unsigned i = 0; i < NUM_EXP; i++) begin
         cfg_regs[i*DATA_W +: DATA_W] = mem_q[i];
      end
   end

   assign wr_err  = wr_err_q;
   assign cfg_upd = cfg_upd_q;

   cfg_reg_rd_pipe #(
      .DATA_W (DATA_W),
      .LAT    (RD_LAT)
   ) u_rd_pipe (
      .clk_i  (clk),
      .rst_ni (rst),
      .vld_i  (rd_en),
      .data_i (old_val),
      .vld_o  (rd_vld),
      .data_o (rd_data)
   );

endmodule
